// File: rtl/plot_fb_pkg.sv
// Purpose : shared types and helpers for the framebuffer write stage (160x120, 3-bit colour).
// Contents: pixel_t request record, pix_addr linear address, on_screen range check.
// Optional: on_screen is only used when PLOT_FB_CLIP_EN is defined.
package plot_fb_pkg;

   localparam int SCREEN_W  = 160;
   localparam int SCREEN_H  = 120;
   localparam int FB_ADDR_W = 15;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] colour;
   } pixel_t;

   // y*160 + x as two shifts and adds; 15 bits hold 119*160+159 = 19199.
   function automatic logic [FB_ADDR_W-1:0] pix_addr(input pixel_t p);
      logic [FB_ADDR_W-1:0] y_w;
      logic [FB_ADDR_W-1:0] x_w;
      y_w = FB_ADDR_W'(p.y);
      x_w = FB_ADDR_W'(p.x);
      return (y_w << 7) + (y_w << 5) + x_w;
   endfunction

   function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y);
      return (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);
   endfunction

endpackage

// File: rtl/plot_fifo.sv
// Purpose : generic synchronous FIFO, DEPTH entries (power of two), element type T.
// Latency : pushed entry visible at head_o the cycle after the push; head_o is a combinational read.
// Backpr. : push ignored when full, pop ignored when empty; clr_i empties it at the next edge.
// Ports   : clk, rst (async high), clr_i, push_i/push_dat_i, pop_i, head_o, full_o, empty_o, count_o.
module plot_fifo #(
   parameter int  DEPTH = 8,
   parameter type T     = plot_fb_pkg::pixel_t,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          push_i,
   input  T              push_dat_i,
   input  logic          pop_i,
   output T              head_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   T              mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_d = count_q + 1'b1;
         else if (!do_push && do_pop) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: only entries below count_q are ever read.
   always_ff @(posedge clk) begin
      if (do_push && !clr_i) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/plot_fb_writer.sv
// Purpose : clips drawer pixels, buffers them in plot_fifo and issues linear framebuffer writes.
// Latency : in_plot in cycle 0 (idle) -> fb_we in cycle 2; one write per cycle while fb_busy=0.
// Backpr. : fb_busy stalls the held write; a full FIFO drops new requests (drop_count), in_ready advisory.
// Ports   : clk, rst (async high), flush, in_x/in_y/in_colour/in_plot, in_ready,
//           fb_addr/fb_wdata/fb_we, fb_busy, drop_count, clip_count.
// Macro   : PLOT_FB_CLIP_EN enables off-screen rejection and clip_count; otherwise clip_count=0.
module plot_fb_writer
   import plot_fb_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic [7:0]           in_x,
   input  logic [6:0]           in_y,
   input  logic [2:0]           in_colour,
   input  logic                 in_plot,
   output logic                 in_ready,
   output logic [FB_ADDR_W-1:0] fb_addr,
   output logic [2:0]           fb_wdata,
   output logic                 fb_we,
   input  logic                 fb_busy,
   output logic [7:0]           drop_count,
   output logic [7:0]           clip_count
);

   localparam int CW = $clog2(DEPTH) + 1;

   pixel_t               in_pix, head_pix;
   logic                 fifo_full, fifo_empty;
   logic [CW-1:0]        fifo_count;
   logic                 clip_hit, req_ok, push, pop, drop_evt;

   logic                 out_vld_q,  out_vld_d;
   logic [FB_ADDR_W-1:0] out_addr_q, out_addr_d;
   logic [2:0]           out_dat_q,  out_dat_d;
   logic [7:0]           drop_q,     drop_d;

   assign in_pix = '{x: in_x, y: in_y, colour: in_colour};

`ifdef PLOT_FB_CLIP_EN
   logic [7:0] clip_q, clip_d;
   assign clip_hit = !on_screen(in_x, in_y);
`else
   assign clip_hit = 1'b0;
`endif

   // A request made during flush is discarded silently, so it feeds no counter.
   assign req_ok   = in_plot && !flush && !clip_hit;
   // Fullness is judged on the registered count: a same-cycle pop does not make room.
   assign push     = req_ok && !fifo_full;
   assign drop_evt = req_ok && fifo_full;
   // Refill the output register when it is idle or its write completes this cycle.
   assign pop      = !flush && !fifo_empty && (!out_vld_q || !fb_busy);

   plot_fifo #(
      .DEPTH (DEPTH),
      .T     (pixel_t)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (flush),
      .push_i     (push),
      .push_dat_i (in_pix),
      .pop_i      (pop),
      .head_o     (head_pix),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count)
   );

   always_comb begin
      out_vld_d  = out_vld_q;
      out_addr_d = out_addr_q;
      out_dat_d  = out_dat_q;
      if (flush) begin
         out_vld_d = 1'b0;
      end else if (pop) begin
         out_vld_d  = 1'b1;
         out_addr_d = pix_addr(head_pix);
         out_dat_d  = head_pix.colour;
      end else if (out_vld_q && !fb_busy) begin
         out_vld_d = 1'b0;
      end
   end

   assign drop_d = (drop_evt && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld_q  <= 1'b0;
         out_addr_q <= '0;
         out_dat_q  <= '0;
         drop_q     <= '0;
      end else begin
         out_vld_q  <= out_vld_d;
         out_addr_q <= out_addr_d;
         out_dat_q  <= out_dat_d;
         drop_q     <= drop_d;
      end
   end

`ifdef PLOT_FB_CLIP_EN
   assign clip_d = (in_plot && !flush && clip_hit && (clip_q != 8'hFF)) ? clip_q + 8'd1 : clip_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) clip_q <= '0;
      else     clip_q <= clip_d;
   end

   assign clip_count = clip_q;
`else
   assign clip_count = 8'd0;
`endif

   assign in_ready   = (fifo_count != CW'(DEPTH));
   assign fb_we      = out_vld_q;
   assign fb_addr    = out_addr_q;
   assign fb_wdata   = out_dat_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_plot_fb_writer.sv
// Directed bench for plot_fb_writer: expected writes are queued when pixels are driven
// and compared in order by a monitor whenever a write completes.
module tb_plot_fb_writer;

`ifdef PLOT_FB_CLIP_EN
   localparam bit CLIP = 1'b1;
`else
   localparam bit CLIP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, flush, in_plot, in_ready, fb_we, fb_busy;
   logic [7:0]  in_x, drop_count, clip_count;
   logic [6:0]  in_y;
   logic [2:0]  in_colour, fb_wdata;
   logic [14:0] fb_addr;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;

   typedef struct {
      logic [14:0] addr;
      logic [2:0]  data;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   plot_fb_writer #(.DEPTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_x       (in_x),
      .in_y       (in_y),
      .in_colour  (in_colour),
      .in_plot    (in_plot),
      .in_ready   (in_ready),
      .fb_addr    (fb_addr),
      .fb_wdata   (fb_wdata),
      .fb_we      (fb_we),
      .fb_busy    (fb_busy),
      .drop_count (drop_count),
      .clip_count (clip_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic plot(input int x, input int y, input int c, input bit exp_wr);
      exp_t e;
      in_x      = 8'(x);
      in_y      = 7'(y);
      in_colour = 3'(c);
      in_plot   = 1'b1;
      if (exp_wr) begin
         e.addr = 15'(y * 160 + x);
         e.data = 3'(c);
         sb_q.push_back(e);
      end
   endtask

   // Completed writes are popped from the scoreboard in order.
   always @(negedge clk) begin
      if (fb_we === 1'b1 && fb_busy === 1'b0) begin
         wr_cnt++;
         checks++;
         assert (sb_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_write: observed write addr %0d, expected no write", fb_addr);
         end
         if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            chk("wr_addr", 32'(fb_addr), 32'(mon_e.addr));
            chk("wr_data", 32'(fb_wdata), 32'(mon_e.data));
         end
      end
   end

   initial begin
      int c0;

      // Reset; a request held during reset must be ignored.
      rst = 1'b1; flush = 1'b0; fb_busy = 1'b0;
      in_x = 8'd5; in_y = 7'd5; in_colour = 3'd1; in_plot = 1'b1;
      repeat (3) tick();
      chk("rst_we", fb_we, 0);
      chk("rst_addr", fb_addr, 0);
      chk("rst_data", fb_wdata, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_clip", clip_count, 0);
      chk("rst_ready", in_ready, 1);
      rst = 1'b0; in_plot = 1'b0;
      repeat (3) tick();
      chk("rst_ignored_plot", wr_cnt, 0);

      // Single pixel latency.
      c0 = wr_cnt;
      plot(80, 60, 2, 1'b1);
      @(negedge clk); chk("lat_c0_we", fb_we, 0);
      tick(); in_plot = 1'b0;
      @(negedge clk); chk("lat_c1_we", fb_we, 0);
      @(negedge clk); chk("lat_c2_we", fb_we, 1);
      chk("lat_c2_addr", fb_addr, 9680);
      chk("lat_c2_data", fb_wdata, 2);
      @(negedge clk); chk("lat_c3_we", fb_we, 0);
      tick(); chk("single_wr_cnt", wr_cnt - c0, 1);

      // Corners on consecutive cycles give back-to-back writes.
      plot(0, 0, 1, 1'b1);
      tick(); plot(159, 119, 7, 1'b1);
      tick(); in_plot = 1'b0;
      @(negedge clk); chk("corner0_we", fb_we, 1); chk("corner0_addr", fb_addr, 0);
      @(negedge clk); chk("corner1_we", fb_we, 1); chk("corner1_addr", fb_addr, 19199);
      @(negedge clk); chk("corner_end_we", fb_we, 0);

      // Off-screen points: clipped with the macro, written unchecked without it.
      tick(); c0 = wr_cnt;
      plot(160, 0, 3, !CLIP);
      tick(); plot(0, 120, 4, !CLIP);
      tick(); in_plot = 1'b0;
      repeat (4) tick();
      chk("clip_count", clip_count, CLIP ? 2 : 0);
      chk("clip_wr_cnt", wr_cnt - c0, CLIP ? 0 : 2);

      // Stall with 10 pushes: 9 held, 1 dropped.
      fb_busy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         plot(i * 10 + 5, i + 3, (i + 1) % 8, i < 9);
         tick();
      end
      in_plot = 1'b0;
      chk("stall_drop", drop_count, 1);
      chk("stall_ready", in_ready, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("stall_we", fb_we, 1);
         chk("stall_addr", fb_addr, 485);
         chk("stall_data", fb_wdata, 1);
      end
      tick(); fb_busy = 1'b0; c0 = wr_cnt;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk); chk("drain_we", fb_we, 1);
      end
      @(negedge clk); chk("drain_end_we", fb_we, 0);
      tick(); chk("drain_wr_cnt", wr_cnt - c0, 9);
      chk("drain_ready", in_ready, 1);

      // Flush discards queued and pending writes and a concurrent request.
      fb_busy = 1'b1; c0 = wr_cnt;
      for (int i = 0; i < 5; i++) begin
         plot(i + 1, 2, 3, 1'b0);
         tick();
      end
      in_plot = 1'b0;
      tick();
      @(negedge clk); chk("pre_flush_we", fb_we, 1);
      tick(); flush = 1'b1; plot(200, 5, 6, 1'b0);
      tick(); flush = 1'b0; in_plot = 1'b0;
      @(negedge clk); chk("flush_we", fb_we, 0); chk("flush_ready", in_ready, 1);
      tick(); fb_busy = 1'b0;
      repeat (6) tick();
      chk("flush_wr_cnt", wr_cnt - c0, 0);
      chk("flush_drop", drop_count, 1);
      chk("flush_clip", clip_count, CLIP ? 2 : 0);

      // Drop counter saturates at 255.
      fb_busy = 1'b1;
      plot(1, 1, 1, 1'b0);
      repeat (270) tick();
      in_plot = 1'b0;
      chk("drop_saturate", drop_count, 255);
      flush = 1'b1; tick(); flush = 1'b0; fb_busy = 1'b0;
      repeat (3) tick();
      chk("sat_flush_we", fb_we, 0);

      // Asynchronous reset with writes pending.
      fb_busy = 1'b1; c0 = wr_cnt;
      for (int i = 0; i < 4; i++) begin
         plot(i + 20, 7, 2, 1'b0);
         tick();
      end
      in_plot = 1'b0;
      tick();
      @(negedge clk); chk("pre_rst_we", fb_we, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_we", fb_we, 0);
      chk("arst_addr", fb_addr, 0);
      chk("arst_data", fb_wdata, 0);
      chk("arst_drop", drop_count, 0);
      chk("arst_clip", clip_count, 0);
      chk("arst_ready", in_ready, 1);
      tick(); plot(9, 9, 1, 1'b0);
      tick(); rst = 1'b0; in_plot = 1'b0; fb_busy = 1'b0;
      repeat (4) tick();
      chk("arst_wr_cnt", wr_cnt - c0, 0);

      // New pixel after reset keeps the two-cycle latency.
      c0 = wr_cnt;
      plot(10, 20, 5, 1'b1);
      tick(); in_plot = 1'b0;
      @(negedge clk); chk("relat_c1_we", fb_we, 0);
      @(negedge clk); chk("relat_c2_we", fb_we, 1);
      chk("relat_c2_addr", fb_addr, 3210);
      chk("relat_c2_data", fb_wdata, 5);
      @(negedge clk); chk("relat_c3_we", fb_we, 0);
      tick(); chk("relat_wr_cnt", wr_cnt - c0, 1);

      chk("sb_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/plot_fb_writer.md
# plot_fb_writer

Framebuffer write stage that sits directly downstream of the circle/shape drawer. It consumes the drawer's fire-and-forget pixel stream (x, y, colour, plot strobe), clips off-screen points and buffers requests in a small FIFO. It converts each surviving point to a linear 160×120 framebuffer address and issues one write per accepted request to a framebuffer memory that may stall. It also counts dropped and clipped pixels for debug visibility on LEDs.

## Interface
- DEPTH, 8: FIFO entries, power of two, 2..64
- SCREEN_W, 160: visible columns
- SCREEN_H, 120: visible rows

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; discards all buffered and pending writes
- in_x  in  8  pixel column
- in_y  in  7  pixel row
- in_colour  in  3  pixel colour
- in_plot  in  1  request strobe; one request per high cycle
- in_ready  out  1  FIFO not full (advisory; drawer may ignore it)
- fb_addr  out  15  in_y*SCREEN_W + in_x
- fb_wdata  out  3  colour
- fb_we  out  1  write valid
- fb_busy  in  1  memory stall; write completes on a cycle with fb_we=1 and fb_busy=0
- drop_count  out  8  requests lost to full FIFO, saturates at 255
- clip_count  out  8  requests rejected as off-screen, saturates at 255

## Operation
- Input stage, each cycle with in_plot=1 and flush=0:
  - If the clip check fails (in_x ≥ SCREEN_W or in_y ≥ SCREEN_H), clip_count increments and nothing is enqueued.
  - Else, if the FIFO is full at the start of the cycle, drop_count increments. A same-cycle pop does not rescue the request.
  - Else, {x, y, colour} is pushed.
- Output register: one pending write (valid/addr/data).
  - Loads from the FIFO head when empty, or when the current write completes this cycle. Back-to-back writes are therefore possible.
- Address: (y<<7)+(y<<5)+x computed at pop time, 15-bit unsigned. Maximum 19199, no overflow.
- Ordering: strictly FIFO; no reordering or merging of duplicate coordinates.
- in_ready = (count != DEPTH), combinational from the registered count.
- flush: FIFO count→0, output valid→0 at the next edge. A concurrent in_plot is discarded and not counted. Counters are retained.
- Total buffering = DEPTH + 1 (FIFO plus output register).

## Timing
- Reset values: fb_we=0, fb_addr=0, fb_wdata=0, drop_count=0, clip_count=0, FIFO empty, in_ready=1.
  - in_plot is ignored while rst=1.
- Latency: in_plot high in cycle 0, FIFO empty, output idle → fb_we=1 with the correct addr/data in cycle 2.
- Throughput: 1 write/cycle while fb_busy=0 and data is available.
- Stall: while fb_busy=1, fb_we/fb_addr/fb_wdata hold stable. This is required behaviour.
- Reset mid-operation: all buffered pixels are lost, no partial write is issued, and outputs take their reset values immediately (async).
- flush and rst together: rst dominates.
- Counter saturation: at 255 further events leave the value at 255, with no wrap.

## Configuration
- PLOT_FB_CLIP_EN defined: clipping as above; clip_count is live.
- Undefined:
  - No range check; every request is enqueued.
  - Address is computed unchecked and may exceed 19199; the caller guarantees in-range coordinates.
  - clip_count is tied to 0.

## Structure
- Package plot_fb_pkg:
  - SCREEN_W, SCREEN_H, FB_ADDR_W=15
  - typedef struct packed pixel_t {x[7:0], y[6:0], colour[2:0]}
  - function pix_addr(pixel_t)
- Sub-module plot_fifo:
  - Parameterised by DEPTH and element type pixel_t.
  - push/pop/full/empty/count, synchronous clear, asynchronous active-high reset.
- Top block holds clip logic, counters and the output register.

## Test plan
- Single pixel (80,60,3'b010), fb_busy=0 → exactly one cycle with fb_we=1 in cycle 2, fb_addr=9680, fb_wdata=3'b010.
- Corners (0,0,1) then (159,119,7) on consecutive cycles → writes at addr 0 then 19199 on consecutive cycles.
- With PLOT_FB_CLIP_EN, (160,0) and (0,120) → no fb_we, clip_count=2. Without the macro → two writes issued.
- fb_busy=1 while 10 pixels are pushed on consecutive cycles (DEPTH=8) → drop_count=1, in_ready=0. Release fb_busy → 9 writes in order on 9 consecutive cycles, addr/data stable throughout the stall.
- 5 pixels queued with fb_busy=1, then flush for 1 cycle with in_plot=1 → fb_we=0 next cycle, no writes after release, counters unchanged.
- rst asserted while 4 writes are pending → fb_we drops immediately, all outputs at reset values; a new pixel after release is written with 2-cycle latency.
